// File: rtl/tile_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_fetch_ctrl_pkg
// Description : Shared definitions for the tile fetch controller: tile
//               geometry, register-file index width, FSM state encoding and a
//               counter-width helper.
// Revision    : 1.0  initial release
// ============================================================================
package tile_fetch_ctrl_pkg;

    localparam int TILE     = 4;    // tile edge in pixels
    localparam int TILE_PIX = 16;   // pixels per tile
    localparam int IDX_W    = 4;    // register-file index width (ADDR_W)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WAITLO = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_fetch_ctrl_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : tile_fetch_ctrl_valid_delay
// Description : Fixed-depth shift register that delays {valid, index} by the
//               ROM read latency so the write strobe lines up with ROM data.
// Ports       : clk  - clock
//               rst  - asynchronous reset, active low
//               din  - {valid, index} at address-issue time
//               dout - {valid, index} delayed DEPTH cycles
// Revision    : 1.0  initial release
// ============================================================================
module tile_fetch_ctrl_valid_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/tile_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tile_fetch_ctrl
// Description : Walks a raster image in 4x4 tiles, issuing ROM addresses and
//               register-file write strobes aligned to ROM data, then offers
//               each tile downstream with a four-phase finish/finish_ack
//               handshake. all_done flags the end of the frame.
// Ports       : clk          - clock
//               rst          - asynchronous reset, active low
//               start        - frame request level; rising edge starts a frame
//               imem_address - ROM read address
//               WR / ADDR_W  - register-file write strobe and index 0..15
//               finish       - tile ready, held until finish_ack
//               finish_ack   - downstream captured the tile
//               all_done     - whole frame delivered
//               tile_count   - tiles acknowledged in the current frame
// Revision    : 1.0  initial release
// ============================================================================
module tile_fetch_ctrl
    import tile_fetch_ctrl_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int AW     = 14,
    parameter int RD_LAT = 1,
    parameter int TW     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [AW-1:0]    imem_address,
    output logic             WR,
    output logic [IDX_W-1:0] ADDR_W,
    output logic             finish,
    input  logic             finish_ack,
    output logic             all_done,
    output logic [TW-1:0]    tile_count
);

    localparam int TX_N = IMG_W / TILE;
    localparam int TY_N = IMG_H / TILE;
    localparam int TXW  = cnt_width(TX_N);
    localparam int TYW  = cnt_width(TY_N);
    localparam int DW   = cnt_width(RD_LAT);

    localparam logic [TXW-1:0]   TX_LAST   = TXW'(TX_N - 1);
    localparam logic [TYW-1:0]   TY_LAST   = TYW'(TY_N - 1);
    localparam logic [DW-1:0]    DRAIN_END = DW'(RD_LAT - 1);
    localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(TILE_PIX - 1);
    localparam logic [AW-1:0]    ROW_STEP  = AW'(IMG_W);          // next pixel row
    localparam logic [AW-1:0]    TROW_STEP = AW'(TILE * IMG_W);   // next tile row
    localparam logic [AW-1:0]    TCOL_STEP = AW'(TILE);           // next tile column

    state_t           state_q, state_d;
    logic             prev_low_q, prev_low_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [TXW-1:0]   tx_q, tx_d;
    logic [TYW-1:0]   ty_q, ty_d;
    logic [AW-1:0]    tile_base_q, tile_base_d;   // address of pixel (0,0) of current tile
    logic [AW-1:0]    tile_row_q, tile_row_d;     // address of pixel (0,0) of tile tx=0 in this tile row
    logic [AW-1:0]    row_base_q, row_base_d;     // address of column 0 of the pixel row being fetched
    logic [AW-1:0]    addr_q, addr_d;
    logic [TW-1:0]    tile_count_q, tile_count_d;

    logic             w_start_rise;
    logic [IDX_W:0]   w_dly_out;

    // prev_low_q resets to 0 so a start level already high at reset release
    // is not mistaken for a rising edge.
    assign w_start_rise = start & prev_low_q;

    always_comb begin
        state_d      = state_q;
        prev_low_d   = ~start;
        k_d          = k_q;
        drain_d      = drain_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        tile_base_d  = tile_base_q;
        tile_row_d   = tile_row_q;
        row_base_d   = row_base_q;
        addr_d       = addr_q;
        tile_count_d = tile_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_start_rise) begin
                    tx_d         = '0;
                    ty_d         = '0;
                    tile_base_d  = '0;
                    tile_row_d   = '0;
                    row_base_d   = '0;
                    addr_d       = '0;
                    k_d          = '0;
                    tile_count_d = '0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (k_q == K_LAST) begin
                    // last address stays on the bus through DRAIN/HOLD
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + IDX_W'(1);
                    if (k_q[1:0] == 2'd3) begin
                        row_base_d = row_base_q + ROW_STEP;
                        addr_d     = row_base_q + ROW_STEP;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d = ST_HOLD;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_HOLD: begin
                if (finish_ack) begin
                    tile_count_d = tile_count_q + TW'(1);
                    if (tx_q == TX_LAST) begin
                        tx_d        = '0;
                        ty_d        = ty_q + TYW'(1);
                        tile_row_d  = tile_row_q + TROW_STEP;
                        tile_base_d = tile_row_q + TROW_STEP;
                    end else begin
                        tx_d        = tx_q + TXW'(1);
                        tile_base_d = tile_base_q + TCOL_STEP;
                    end
                    if ((tx_q == TX_LAST) && (ty_q == TY_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAITLO;
                    end
                end
            end
            ST_WAITLO: begin
                // four-phase return-to-zero before the next tile is fetched
                if (!finish_ack) begin
                    k_d        = '0;
                    row_base_d = tile_base_q;
                    addr_d     = tile_base_q;
                    state_d    = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            prev_low_q   <= 1'b0;
            k_q          <= '0;
            drain_q      <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            tile_base_q  <= '0;
            tile_row_q   <= '0;
            row_base_q   <= '0;
            addr_q       <= '0;
            tile_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_low_q   <= prev_low_d;
            k_q          <= k_d;
            drain_q      <= drain_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            tile_base_q  <= tile_base_d;
            tile_row_q   <= tile_row_d;
            row_base_q   <= row_base_d;
            addr_q       <= addr_d;
            tile_count_q <= tile_count_d;
        end
    end

    tile_fetch_ctrl_valid_delay #(
        .DEPTH (RD_LAT),
        .W     (IDX_W + 1)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({(state_q == ST_FETCH), k_q}),
        .dout (w_dly_out)
    );

    assign WR           = w_dly_out[IDX_W];
    assign ADDR_W       = w_dly_out[IDX_W-1:0];
    assign imem_address = addr_q;
    assign finish       = (state_q == ST_HOLD);
    assign all_done     = (state_q == ST_DONE);
    assign tile_count   = tile_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_fetch_ctrl
// Description : Self-checking bench for tile_fetch_ctrl on an 8x8 image
//               (4 tiles). A timeline model of each tile predicts every
//               output cycle by cycle; a ROM/register-file model checks data
//               alignment; a second instance with RD_LAT=3 checks latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tile_fetch_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int AW    = 14;
    localparam int TW    = 10;
    localparam int LAT   = 1;
    localparam int LAT3  = 3;
    localparam int TXN   = IMG_W / 4;
    localparam int NT    = (IMG_W / 4) * (IMG_H / 4);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b1;
    logic          ack = 1'b0;
    logic          ack3 = 1'b0;

    logic [AW-1:0] imem_address, imem_address3;
    logic          WR, WR3, finish, finish3, all_done, all_done3;
    logic [3:0]    ADDR_W, ADDR_W3;
    logic [TW-1:0] tile_count, tile_count3;

    tile_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .RD_LAT(LAT), .TW(TW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .imem_address(imem_address), .WR(WR),
        .ADDR_W(ADDR_W), .finish(finish), .finish_ack(ack), .all_done(all_done),
        .tile_count(tile_count)
    );

    tile_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .RD_LAT(LAT3), .TW(TW)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .imem_address(imem_address3), .WR(WR3),
        .ADDR_W(ADDR_W3), .finish(finish3), .finish_ack(ack3), .all_done(all_done3),
        .tile_count(tile_count3)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // address of pixel j (row-major) of tile t in raster order
    function automatic int pix_addr(input int t, input int j);
        return (4 * (t / TXN) + j / 4) * IMG_W + 4 * (t % TXN) + j % 4;
    endfunction

    // ---------------- ROM and register-file model ----------------
    logic [7:0] rom_q;
    logic [7:0] rf [16];
    always @(posedge clk) begin
        if (WR) rf[ADDR_W] <= rom_q;
        rom_q <= imem_address[7:0];
    end

    // ---------------- behavioural model ----------------
    // phase 0 idle, 1 tile in progress (j = cycles since first address),
    // 2 waiting for ack to drop, 3 frame done
    int m_phase, m_j, m_tile, m_cnt;
    bit m_prev_low;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_j = 0; m_tile = 0; m_cnt = 0; m_prev_low = 0;
        end else begin
            case (m_phase)
                0: if (start && m_prev_low) begin
                       m_phase = 1; m_j = 0; m_tile = 0; m_cnt = 0;
                   end
                1: if (m_j < 16 + LAT) m_j++;
                   else if (ack) begin
                       m_cnt++;
                       if (m_tile == NT - 1) m_phase = 3;
                       else begin m_tile++; m_phase = 2; end
                   end
                2: if (!ack) begin m_phase = 1; m_j = 0; end
                3: if (!start) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_prev_low = !start;
        end
    end

    // ---------------- compare process ----------------
    int cyc = 0;
    int m_last_addr = 0;
    bit rec_en = 0;
    int obs [4][16];
    int f_cyc = -1;
    int d3_cnt = 0, d3_first = -1, d3_last = -1;
    bit d3_order = 1, d3_checked = 0;

    always @(negedge clk) begin
        int  exp_addr, exp_aw;
        bit  exp_wr, exp_fin, rf_ok;
        cyc++;
        if (!rst) m_last_addr = 0;
        exp_addr = m_last_addr;
        exp_wr = 0; exp_fin = 0; exp_aw = 0;
        if (rst && m_phase == 1) begin
            exp_addr = pix_addr(m_tile, (m_j < 16) ? m_j : 15);
            exp_wr   = (m_j >= LAT) && (m_j < 16 + LAT);
            exp_aw   = m_j - LAT;
            exp_fin  = (m_j >= 16 + LAT);
        end
        m_last_addr = exp_addr;
        check("imem_address", imem_address, exp_addr);
        check("WR", WR, exp_wr);
        if (exp_wr) check("ADDR_W", ADDR_W, exp_aw);
        check("finish", finish, exp_fin);
        check("all_done", all_done, (rst && m_phase == 3));
        check("tile_count", tile_count, m_cnt);
        if (exp_fin) begin
            rf_ok = 1;
            for (int k = 0; k < 16; k++)
                if (rf[k] !== 8'(pix_addr(m_tile, k) & 255)) rf_ok = 0;
            check("regfile_tile", rf_ok, 1);
        end
        if (rec_en && m_phase == 1 && m_j < 16) begin
            obs[m_tile][m_j] = imem_address;
            if (m_tile == 0 && m_j == 0 && f_cyc < 0) f_cyc = cyc;
        end
        // RD_LAT=3 instance, first tile of the first frame
        if (f_cyc >= 0 && !d3_checked) begin
            if (WR3) begin
                if (ADDR_W3 != d3_cnt[3:0]) d3_order = 0;
                if (d3_first < 0) d3_first = cyc;
                d3_last = cyc;
                d3_cnt++;
            end
            if (finish3) begin
                d3_checked = 1;
                check("lat3_wr_count", d3_cnt, 16);
                check("lat3_first_wr_delay", d3_first - f_cyc, 3);
                check("lat3_last_wr_delay", d3_last - f_cyc, 18);
                check("lat3_finish_after_last_wr", cyc - d3_last, 1);
                check("lat3_addr_w_order", d3_order, 1);
            end
        end
    end

    // RD_LAT=3 instance acknowledges immediately
    initial forever begin
        @(posedge clk); #1;
        ack3 = finish3;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic serve_tile(input int dly, input int hold);
        int w;
        w = 0;
        while (!finish && w < 200) begin tick(1); w++; end
        check("finish_arrives", finish, 1);
        tick(dly);
        ack = 1'b1;
        tick(hold);
        ack = 1'b0;
    endtask

    initial begin
        int c;
        int tile0_exp [16] = '{0,1,2,3,8,9,10,11,16,17,18,19,24,25,26,27};

        // reset with start already high: no frame may start
        rst = 1'b0; start = 1'b1; ack = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(6);
        check("idle_after_reset_addr", imem_address, 0);
        check("idle_after_reset_wr", WR, 0);

        // frame 1
        start = 1'b0; tick(2);
        start = 1'b1; rec_en = 1;
        serve_tile(10, 5);       // slow ack, then held high 5 cycles
        serve_tile(0, 1);
        tick(4); start = 1'b0;   // start toggle during tile 2 fetch
        tick(2); start = 1'b1;
        serve_tile(3, 2);
        serve_tile(0, 1);
        c = 0;
        while (!all_done && c < 100) begin tick(1); c++; end
        check("frame1_tile_count", tile_count, 4);
        check("frame1_all_done", all_done, 1);
        rec_en = 0;
        for (int k = 0; k < 16; k++) check("tile0_addr", obs[0][k], tile0_exp[k]);
        check("tile1_first_addr", obs[1][0], 4);
        check("tile2_first_addr", obs[2][0], 32);
        check("tile3_first_addr", obs[3][0], 36);
        check("tile3_last_addr", obs[3][15], 63);

        // leave DONE, restart
        tick(3); start = 1'b0;
        tick(1);
        check("all_done_drops", all_done, 0);
        tick(2); start = 1'b1;
        tick(1);
        check("restart_addr0", imem_address, 0);

        // reset in the middle of tile 1 fetch
        serve_tile(0, 1);
        tick(6);
        #3 rst = 1'b0;
        #1;
        check("rst_addr", imem_address, 0);
        check("rst_wr", WR, 0);
        check("rst_finish", finish, 0);
        check("rst_tile_count", tile_count, 0);
        check("rst_all_done", all_done, 0);
        tick(2); rst = 1'b1;
        tick(1); start = 1'b0;
        tick(1); start = 1'b1;

        // randomized acknowledge pattern for a whole frame
        c = 0;
        while (!all_done && c < 3000) begin
            ack = 1'($urandom_range(0, 1));
            tick(1);
            c++;
        end
        ack = 1'b0;
        check("random_frame_done", all_done, 1);
        check("random_frame_tile_count", tile_count, 4);
        check("lat3_checked", d3_checked, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
